uart_tx_feeder: RTL
===================

// Module: uart_tx_feeder
// PURPOSE
// - Byte buffer + issue FSM directly upstream of the UART TX: a FIFO accepts bytes from the register/system side,
//   presents one byte at a time on tx_p_data with a 1-cycle tx_data_valid pulse, paces issue on UART tx_busy.
// - Shields writers from UART frame timing; guarantees one byte per frame, in order, no byte lost unless FIFO full.
// PARAMETERS
// - DATA_WIDTH     8  width of a UART data word
// - FIFO_DEPTH     8  FIFO entries; power of 2, >=2
// - BUSY_WAIT_MAX  4  cycles to wait for tx_busy to rise after a pulse before abandoning the handshake
// PORTS
// - clk            in   1                          single clock; all logic on rising edge
// - rst_n          in   1                          reset, synchronous, active-low
// - wr_data        in   DATA_WIDTH                 byte to enqueue
// - wr_en          in   1                          enqueue request; accepted iff !full at that edge
// - full           out  1                          fill_count == FIFO_DEPTH
// - empty          out  1                          fill_count == 0
// - fill_count     out  $clog2(FIFO_DEPTH)+1       entries held
// - tx_p_data      out  DATA_WIDTH                 byte to UART TX; registered, held until next issue
// - tx_data_valid  out  1                          1-cycle issue pulse to UART TX
// - tx_busy        in   1                          UART TX busy (high for whole frame)
// - overflow       out  1                          sticky write-when-full flag (only with UART_TX_FEEDER_OVF_EN)
// BEHAVIOUR
// - Reset (rst_n=0 at edge): ptrs=0, fill_count=0, empty=1, full=0, tx_p_data=0, tx_data_valid=0,
//   overflow=0, state=IDLE. Reset mid-frame discards all buffered and in-flight bytes; no pulse follows.
// - All outputs registered. FIFO: circular, write/read ptrs wrap modulo FIFO_DEPTH.
// - fill_count: +1 on accepted write, -1 on pop, unchanged if both same edge.
// - Write when full rejected even if a pop occurs same edge; byte dropped, state unchanged.
// - FSM states:
//   IDLE      : if !empty -> SEND; load tx_p_data<=head, tx_data_valid<=1, pop.
//   SEND      : tx_data_valid<=0; -> WAIT_BUSY; clear wait counter.
//   WAIT_BUSY : tx_busy=1 -> WAIT_DONE; else count; count==BUSY_WAIT_MAX-1 -> IDLE (handshake abandoned,
//               byte considered sent).
//   WAIT_DONE : tx_busy=0 -> IDLE; else stay.
// - Latency: wr_en into empty FIFO at edge k -> tx_data_valid high from edge k+1 to k+2, exactly 1 cycle.
// - After tx_busy falls (edge m), next pulse earliest at edge m+1 (IDLE at m, SEND at m+1). Never a second pulse
//   while tx_busy high or before it has been seen high (or timeout).
// - tx_p_data stable from issue until the next issue.
// - Write into empty FIFO on the same edge the FSM is in IDLE: FSM sees empty; byte issued next edge.
// CONFIGURATION
// - UART_TX_FEEDER_OVF_EN defined: overflow port present; set on any rejected write (wr_en & full),
//   cleared only by reset.
// - Undefined: overflow port and logic absent; rejected writes silently dropped.
// TESTING
// - Reset: hold rst_n=0 2 cycles with wr_en=1 -> empty=1, fill_count=0, tx_data_valid=0, tx_p_data=0.
// - Single byte: write 0xA5 at edge k, model busy high 11 cycles from k+3 -> one tx_data_valid pulse edge k+1..k+2,
//   tx_p_data=0xA5, no further pulse, empty=1.
// - Burst: write 0x01..0x08 back-to-back (busy model 11-cycle frames) -> full=1 after 8th accepted (minus pops),
//   pulses emit 0x01..0x08 in order, each pulse >=1 cycle after busy fell.
// - Overflow: fill FIFO with busy forced 1, write 0xFF -> fill_count stays 8, 0xFF never emitted,
//   overflow=1 (macro on); port absent (macro off).
// - Timeout: busy held 0, write 0x3C then 0x4D -> 0x3C pulse, return to IDLE after BUSY_WAIT_MAX cycles,
//   then 0x4D pulse.
// - Reset mid-frame: 3 bytes queued, assert rst_n=0 during WAIT_DONE -> all cleared, no pulse after reset release.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//   Byte FIFO and issue FSM sitting directly in front of a UART transmitter.
//   Writers push bytes whenever the FIFO is not full. The FSM pops one byte at a
//   time, presents it on tx_p_data with a single-cycle tx_data_valid pulse, and
//   then waits for the UART to report a complete frame on tx_busy before it
//   issues the next byte.
//
//   Handshake after each issue:
//     - tx_busy is expected to rise within BUSY_WAIT_MAX cycles. If it never
//       rises, the byte is treated as sent and the FSM returns to IDLE.
//     - Once tx_busy has been seen high, the next byte is held back until
//       tx_busy falls.
//
//   Optional feature (compile-time macro UART_TX_FEEDER_OVF_EN):
//     Adds the 'overflow' output, a sticky flag that is set by any write
//     attempted while the FIFO is full and is cleared only by reset. Without the
//     macro, writes to a full FIFO are dropped silently and the port is absent.
//
//   Reset is synchronous and active-low. All outputs come straight from
//   registers.
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,   // power of 2, >= 2
    parameter int BUSY_WAIT_MAX = 4    // >= 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill_count,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
`ifdef UART_TX_FEEDER_OVF_EN
    output logic                          overflow,
`endif
    input  logic                          tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,  // waiting for a byte in the FIFO
        ST_SEND      = 2'd1,  // issue pulse is on the wire this cycle
        ST_WAIT_BUSY = 2'd2,  // waiting (bounded) for the UART to raise tx_busy
        ST_WAIT_DONE = 2'd3   // frame in progress, waiting for tx_busy to fall
    } state_t;

    // ---------------------------------------------------------------------
    // State and storage
    // ---------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fill;
    logic                  r_full;
    logic                  r_empty;

    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic [WAIT_W-1:0]     r_wait_cnt;

    // Combinational controls
    logic                  w_wr_accept;   // write lands in the FIFO this edge
    logic                  w_pop;         // head leaves the FIFO this edge
    logic                  w_issue;       // load tx_p_data and pulse valid
    logic                  w_wait_clr;    // restart the tx_busy timeout
    logic                  w_wait_inc;    // advance the tx_busy timeout
    logic [CNT_W-1:0]      w_fill_nxt;

    // A write is judged against the registered full flag only. A pop on the
    // same edge does not make room for it.
    assign w_wr_accept = wr_en & ~r_full;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // Hold the current issue state, returning to IDLE on reset.
    always_ff @(posedge clk) begin
        // NOTE: every clocked block uses non-blocking '<=' so that all
        // registers sample pre-edge values, whatever the block ordering.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // Decide the next state from the FIFO level, tx_busy and the timeout counter.
    always_comb begin
        // NOTE: default assignment first so that no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    // The UART never acknowledged. Treat the byte as sent.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output / control decode
    // ---------------------------------------------------------------------
    // Derive pop, issue and timeout-counter controls from the current state.
    always_comb begin
        w_pop      = 1'b0;
        w_issue    = 1'b0;
        w_wait_clr = 1'b0;
        w_wait_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The registered empty flag is used here, so a byte written on
                // this same edge is only seen on the next one.
                if (!r_empty) begin
                    w_pop   = 1'b1;
                    w_issue = 1'b1;
                end
            end
            ST_SEND: begin
                w_wait_clr = 1'b1;
            end
            ST_WAIT_BUSY: begin
                if (!tx_busy && (r_wait_cnt != WAIT_LAST)) begin
                    w_wait_inc = 1'b1;
                end
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // tx_busy timeout counter
    // ---------------------------------------------------------------------
    // Count the cycles spent in WAIT_BUSY without seeing tx_busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_wait_clr) begin
            r_wait_cnt <= '0;
        end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // FIFO storage
    // ---------------------------------------------------------------------
    // Write accepted bytes into the circular buffer.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset. Validity is tracked by the
        // pointers and fill count, and leaving it out keeps the array as
        // plain RAM.
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Advance the write and read pointers. They wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Next fill level: up on write, down on pop, unchanged if both happen.
    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_wr_accept, w_pop})
            2'b10:   w_fill_nxt = r_fill + CNT_W'(1);
            2'b01:   w_fill_nxt = r_fill - CNT_W'(1);
            default: w_fill_nxt = r_fill;
        endcase
    end

    // Register the fill level together with full/empty decoded from it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_fill  <= w_fill_nxt;
            r_full  <= (w_fill_nxt == DEPTH_CNT);
            r_empty <= (w_fill_nxt == '0);
        end
    end

    // ---------------------------------------------------------------------
    // UART-side outputs
    // ---------------------------------------------------------------------
    // Load the head byte on issue and hold it until the next issue. The valid
    // output is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= w_issue;
            if (w_issue) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic r_overflow;

    // Sticky flag: set by any write attempted while full, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_en && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

    assign full          = r_full;
    assign empty         = r_empty;
    assign fill_count    = r_fill;
    assign tx_p_data     = r_tx_data;
    assign tx_data_valid = r_tx_valid;

endmodule
